// File: rtl/multicycle_control_if.sv
// Control-unit bundle: memory handshake, fetched instruction, ALU flag in; datapath controls out.
// slave is the control unit's view, master is the datapath/memory side.
interface multicycle_control_if #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ALU_OP_WIDTH   = 3
);
    logic [31:0]               instr_in;
    logic                      mem_ready;
    logic                      alu_zero;
    logic                      mem_read;
    logic                      mem_write;
    logic                      i_or_d;
    logic                      ir_write;
    logic                      pc_write;
    logic [1:0]                pc_src;
    logic                      pc_load;
    logic                      reg_write;
    logic                      mem_to_reg;
    logic                      alu_src;
    logic [ALU_OP_WIDTH-1:0]   alu_op;
    logic [REG_ADDR_WIDTH-1:0] addr_a;
    logic [REG_ADDR_WIDTH-1:0] addr_b;
    logic [REG_ADDR_WIDTH-1:0] addr_in;
    logic [REG_ADDR_WIDTH-1:0] shamt;
    logic [15:0]               imm16;
    logic [25:0]               addr26;
    logic                      is_branch;
    logic                      is_jump;
    logic                      fault;
    logic [2:0]                state;

    modport slave (
        input  instr_in, mem_ready, alu_zero,
        output mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src, pc_load,
               reg_write, mem_to_reg, alu_src, alu_op, addr_a, addr_b, addr_in,
               shamt, imm16, addr26, is_branch, is_jump, fault, state
    );

    modport master (
        output instr_in, mem_ready, alu_zero,
        input  mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src, pc_load,
               reg_write, mem_to_reg, alu_src, alu_op, addr_a, addr_b, addr_in,
               shamt, imm16, addr26, is_branch, is_jump, fault, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB control unit; 3-5 cycles per instruction with mem_ready high.
// Stalls in FETCH/MEM while mem_ready is low; traps after WAIT_LIMIT consecutive stall cycles.
module multicycle_control #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ALU_OP_WIDTH   = 3,
    parameter int LINK_REG       = 31,
    parameter int WAIT_LIMIT     = 15
) (
    input logic                clk,
    input logic                reset,
    multicycle_control_if.slave bus
);
    localparam int CW = $clog2(WAIT_LIMIT + 1);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [ALU_OP_WIDTH-1:0] OP_ADD = ALU_OP_WIDTH'(0);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SUB = ALU_OP_WIDTH'(1);
    localparam logic [ALU_OP_WIDTH-1:0] OP_AND = ALU_OP_WIDTH'(2);
    localparam logic [ALU_OP_WIDTH-1:0] OP_OR  = ALU_OP_WIDTH'(3);
    localparam logic [ALU_OP_WIDTH-1:0] OP_NOR = ALU_OP_WIDTH'(4);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SLT = ALU_OP_WIDTH'(5);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SLL = ALU_OP_WIDTH'(6);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SRL = ALU_OP_WIDTH'(7);

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_JAL   = 6'h03;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    logic [2:0]    state_q, state_d;
    logic [31:0]   ir_q, ir_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d, wait_inc;
    logic          fault_q, fault_d;

    logic [5:0] opcode, funct;
    logic       is_rtype, is_jr, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, taken;
    logic       legal, rtype_legal, exec_src;
    logic [ALU_OP_WIDTH-1:0] exec_op, rtype_op;

    assign opcode   = ir_q[31:26];
    assign funct    = ir_q[5:0];
    assign is_rtype = (opcode == OPC_RTYPE);
    assign is_jr    = is_rtype && (funct == FN_JR);
    assign is_lw    = (opcode == OPC_LW);
    assign is_sw    = (opcode == OPC_SW);
    assign is_beq   = (opcode == OPC_BEQ);
    assign is_bne   = (opcode == OPC_BNE);
    assign is_j     = (opcode == OPC_J);
    assign is_jal   = (opcode == OPC_JAL);
    assign taken    = (is_beq && bus.alu_zero) || (is_bne && !bus.alu_zero);

    assign bus.addr_a    = REG_ADDR_WIDTH'(ir_q[25:21]);
    assign bus.addr_b    = REG_ADDR_WIDTH'(ir_q[20:16]);
    assign bus.shamt     = REG_ADDR_WIDTH'(ir_q[10:6]);
    assign bus.imm16     = ir_q[15:0];
    assign bus.addr26    = ir_q[25:0];
    assign bus.addr_in   = is_jal   ? REG_ADDR_WIDTH'(LINK_REG) :
                           is_rtype ? REG_ADDR_WIDTH'(ir_q[15:11]) :
                                      REG_ADDR_WIDTH'(ir_q[20:16]);
    assign bus.is_branch = is_beq || is_bne;
    assign bus.is_jump   = is_j || is_jal || is_jr;
    assign bus.fault     = fault_q;
    assign bus.state     = state_q;

    always_comb begin
        rtype_op    = OP_ADD;
        rtype_legal = 1'b1;
        case (funct)
            FN_ADD:  rtype_op = OP_ADD;
            FN_SUB:  rtype_op = OP_SUB;
            FN_AND:  rtype_op = OP_AND;
            FN_OR:   rtype_op = OP_OR;
            FN_NOR:  rtype_op = OP_NOR;
            FN_SLT:  rtype_op = OP_SLT;
            FN_SLL:  rtype_op = OP_SLL;
            FN_SRL:  rtype_op = OP_SRL;
            FN_JR:   rtype_op = OP_ADD;
            default: rtype_legal = 1'b0;
        endcase

        exec_op  = OP_ADD;
        exec_src = 1'b0;
        legal    = 1'b1;
        case (opcode)
            OPC_RTYPE: begin
                exec_op = rtype_op;
                legal   = rtype_legal;
            end
            OPC_ADDI, OPC_LW, OPC_SW: exec_src = 1'b1;
            OPC_ANDI: begin exec_op = OP_AND; exec_src = 1'b1; end
            OPC_ORI:  begin exec_op = OP_OR;  exec_src = 1'b1; end
            OPC_BEQ, OPC_BNE: exec_op = OP_SUB;
            OPC_J, OPC_JAL: ;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        wait_cnt_d = wait_cnt_q;
        wait_inc   = wait_cnt_q + CW'(1);

        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.i_or_d     = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.pc_src     = 2'd0;
        bus.pc_load    = 1'b0;
        bus.reg_write  = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_src    = 1'b0;
        bus.alu_op     = OP_ADD;

        case (state_q)
            S_FETCH: begin
                bus.mem_read = 1'b1;
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    ir_d         = bus.instr_in;
                    wait_cnt_d   = '0;
                    state_d      = S_DECODE;
                end else begin
                    wait_cnt_d = wait_inc;
                    if (wait_inc == CW'(WAIT_LIMIT)) state_d = S_TRAP;
                end
            end
            S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                bus.alu_op  = exec_op;
                bus.alu_src = exec_src;
                state_d     = S_WB;
                if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else if (is_beq || is_bne) begin
                    bus.pc_load = taken;
                    bus.pc_src  = taken ? 2'd1 : 2'd0;
                    state_d     = S_FETCH;
                end else if (is_j || is_jal) begin
                    bus.pc_load = 1'b1;
                    bus.pc_src  = 2'd2;
                    state_d     = is_jal ? S_WB : S_FETCH;
                end else if (is_jr) begin
                    bus.pc_load = 1'b1;
                    bus.pc_src  = 2'd3;
                    state_d     = S_FETCH;
                end
            end
            S_MEM: begin
                bus.i_or_d    = 1'b1;
                bus.mem_read  = is_lw;
                bus.mem_write = is_sw;
                if (bus.mem_ready) begin
                    wait_cnt_d = '0;
                    state_d    = is_lw ? S_WB : S_FETCH;
                end else begin
                    wait_cnt_d = wait_inc;
                    if (wait_inc == CW'(WAIT_LIMIT)) state_d = S_TRAP;
                end
            end
            S_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = is_lw;
                state_d        = S_FETCH;
            end
            S_TRAP: ;
            default: state_d = S_TRAP;
        endcase

        // Each FETCH/MEM visit gets a fresh stall budget.
        if ((state_d == S_FETCH || state_d == S_MEM) && (state_d != state_q))
            wait_cnt_d = '0;

        fault_d = fault_q || (state_d == S_TRAP);

        // A reset cycle must not commit any architectural write, even mid-access.
        if (reset) begin
            bus.mem_write = 1'b0;
            bus.reg_write = 1'b0;
            bus.pc_load   = 1'b0;
            bus.pc_write  = 1'b0;
            bus.ir_write  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            ir_q       <= '0;
            wait_cnt_q <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            wait_cnt_q <= wait_cnt_d;
            fault_q    <= fault_d;
        end
    end
endmodule
